// File: rtl/serial_bus_master.sv
// Master-side engine for the shared serial bus. It serialises one request as
// start/ID/address/data and returns read data or a timeout status.
module serial_bus_master #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDRESS_WIDTH  = 15,
   parameter int SLAVE_ID_WIDTH = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rd_wrt,
   input  logic [SLAVE_ID_WIDTH-1:0] req_slave_id,
   input  logic [ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      resp_valid,
   output logic [DATA_WIDTH-1:0]     resp_rdata,
   output logic                      resp_timeout,
   output logic                      bus_util,
   output logic                      rd_wrt,
   inout  wire                       data_bus_serial,
   input  logic                      slave_busy
);

   localparam int CW = $clog2(ADDRESS_WIDTH + DATA_WIDTH + SLAVE_ID_WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] ID_LAST   = CW'(SLAVE_ID_WIDTH - 1);
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRESS_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, START, ID, ADDR, WAIT_BUSY, WDATA, RD_WAIT, RDATA, DONE
   } state_t;

   state_t                    state, state_next;
   logic                      dir;
   logic [SLAVE_ID_WIDTH-1:0] id_sr;
   logic [ADDRESS_WIDTH-1:0]  addr_sr;
   logic [DATA_WIDTH-1:0]     data_sr;
   logic [DATA_WIDTH-1:0]     rx_word;
   logic [CW-1:0]             bit_cnt;
   logic [TW-1:0]             tcnt;
   logic                      drive_en, drive_val, abort, line_in, accept;

   assign data_bus_serial = drive_en ? drive_val : 1'bz;
   assign line_in         = data_bus_serial;
   assign accept          = (state == IDLE) && req_valid;
   // The bit sampled on the closing edge of the last RDATA cycle completes the word.
   assign rx_word         = DATA_WIDTH'({data_sr, line_in});

   always_comb begin
      state_next = state;
      drive_en   = 1'b0;
      drive_val  = 1'b1;
      bus_util   = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      abort      = 1'b0;
      rd_wrt     = (state != IDLE) && dir;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = START;
         end
         START: begin
            drive_en   = 1'b1;
            drive_val  = 1'b0;
            bus_util   = 1'b1;
            state_next = ID;
         end
         ID: begin
            drive_en  = 1'b1;
            drive_val = id_sr[SLAVE_ID_WIDTH-1];
            bus_util  = 1'b1;
            if (bit_cnt == ID_LAST) state_next = ADDR;
         end
         ADDR: begin
            drive_en  = 1'b1;
            drive_val = addr_sr[ADDRESS_WIDTH-1];
            bus_util  = 1'b1;
            if (bit_cnt == ADDR_LAST) state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            drive_en = dir;
            // Testing busy high (not low) lets an unknown busy line count as idle.
            if (slave_busy) begin
               if (tcnt == T_LAST) begin
                  abort      = 1'b1;
                  state_next = DONE;
               end
            end else begin
               state_next = dir ? WDATA : RD_WAIT;
            end
         end
         WDATA: begin
            drive_en  = 1'b1;
            drive_val = data_sr[DATA_WIDTH-1];
            if (bit_cnt == DATA_LAST) state_next = DONE;
         end
         RD_WAIT: begin
            if (!line_in) begin
               state_next = RDATA;
            end else if (tcnt == T_LAST) begin
               abort      = 1'b1;
               state_next = DONE;
            end
         end
         RDATA: begin
            if (bit_cnt == DATA_LAST) state_next = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         dir          <= 1'b0;
         bit_cnt      <= '0;
         tcnt         <= '0;
         resp_rdata   <= '0;
         resp_timeout <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) dir <= req_rd_wrt;
         bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
         if (state_next != state) begin
            tcnt <= '0;
         end else if (state == WAIT_BUSY || state == RD_WAIT) begin
            tcnt <= tcnt + 1'b1;
         end
         if (state_next == DONE && state != DONE) begin
            resp_timeout <= abort;
            resp_rdata   <= (abort || dir) ? '0 : rx_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         id_sr   <= req_slave_id;
         addr_sr <= req_addr;
         data_sr <= req_wdata;
      end else begin
         case (state)
            ID:      id_sr   <= id_sr << 1;
            ADDR:    addr_sr <= addr_sr << 1;
            WDATA:   data_sr <= data_sr << 1;
            RDATA:   data_sr <= rx_word;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bus_master.sv
// Bench for serial_bus_master: directed and random frames checked cycle by
// cycle against a frame-position model, with an open-drain slave model.
module tb_serial_bus_master;

   localparam int DW  = 8;
   localparam int AW  = 15;
   localparam int SW  = 2;
   localparam int TO  = 16;
   localparam int HDR = 1 + SW + AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_rd_wrt;
   logic [SW-1:0] req_slave_id;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid, resp_timeout, bus_util, rd_wrt, slave_busy;
   logic [DW-1:0] resp_rdata;
   logic          slv_drv;
   tri1           data_bus_serial;

   assign data_bus_serial = slv_drv ? 1'b0 : 1'bz;

   serial_bus_master #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SLAVE_ID_WIDTH(SW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rd_wrt(req_rd_wrt),
      .req_slave_id(req_slave_id), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
      .bus_util(bus_util), .rd_wrt(rd_wrt),
      .data_bus_serial(data_bus_serial), .slave_busy(slave_busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, req_ready, 1);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_rdata"}, resp_rdata, 0);
      check({tag, "_timeout"}, resp_timeout, 0);
      check({tag, "_bus_util"}, bus_util, 0);
      check({tag, "_rd_wrt"}, rd_wrt, 0);
      check({tag, "_line"}, data_bus_serial, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1; slv_drv = 1'b0; slave_busy = 1'b0; req_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // b: WAIT_BUSY cycles with busy high; s_off: slave start bit offset into RD_WAIT.
   task automatic run_txn(input bit wr, input logic [SW-1:0] id, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int b, input bit respond,
                          input int s_off, input logic [DW-1:0] rd,
                          input int pulse_k, input int rst_k);
      int done, rdstart, s, idx;
      bit tmo;
      logic exp_line;
      logic [HDR-1:0] hdr;
      hdr     = {1'b0, id, addr};
      rdstart = HDR + b + 2;
      s       = rdstart + s_off;
      if (b >= TO) begin
         tmo = 1; done = HDR + TO + 1;
      end else if (wr) begin
         tmo = 0; done = HDR + b + 1 + DW + 1;
      end else if (respond && s_off < TO) begin
         tmo = 0; done = s + DW + 1;
      end else begin
         tmo = 1; done = rdstart + TO;
      end

      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      check("ready_before_req", req_ready, 1);
      if (!req_ready) begin
         do_reset();
         return;
      end
      req_rd_wrt = wr; req_slave_id = id; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1; slave_busy = (b > 0); slv_drv = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;

      for (int k = 1; k <= done; k++) begin
         slave_busy = (k < HDR + 1 + b);
         idx = k - s;
         slv_drv = !wr && respond && (k == s || (idx >= 1 && idx <= DW && rd[DW - idx] == 1'b0));
         if (k == pulse_k) begin
            req_valid = 1'b1; req_addr = AW'($urandom); req_rd_wrt = ~wr;
         end else begin
            req_valid = 1'b0;
         end
         if (k == rst_k) begin
            #2 rst = 1'b1;
            #1 check_reset_outputs("async_rst");
            slv_drv = 1'b0; req_valid = 1'b0;
            repeat (2) @(posedge clk);
            check_reset_outputs("held_rst");
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
         if (k <= HDR) exp_line = hdr[HDR - k];
         else if (!wr) exp_line = !slv_drv;
         else if (k == done) exp_line = 1'b1;
         else if (tmo || k <= HDR + b + 1) exp_line = 1'b1;
         else exp_line = wd[DW - 1 - (k - HDR - b - 2)];
         check("line", data_bus_serial, exp_line);
         check("bus_util", bus_util, k <= HDR);
         check("resp_valid", resp_valid, k == done);
         check("req_ready_busy", req_ready, 0);
         if (k <= HDR) check("rd_wrt", rd_wrt, wr);
         if (k == done) begin
            check("resp_timeout", resp_timeout, tmo);
            if (tmo || !wr) check("resp_rdata", resp_rdata, tmo ? 0 : rd);
         end
         if (k < done) begin
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
      slv_drv = 1'b0; slave_busy = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("idle_ready", req_ready, 1);
      check("idle_rd_wrt", rd_wrt, 0);
      check("idle_resp_valid", resp_valid, 0);
      check("idle_line", data_bus_serial, 1);
      check("hold_timeout", resp_timeout, tmo);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit wr, rsp;
      rst = 1'b1; req_valid = 1'b0; req_rd_wrt = 1'b0; req_slave_id = '0;
      req_addr = '0; req_wdata = '0; slave_busy = 1'b0; slv_drv = 1'b0;
      #1 check_reset_outputs("por");
      do_reset();

      run_txn(1, 2'b11, 15'h1234, 8'h9F, 0, 0, 0, 8'h00, 0, 0);
      run_txn(0, 2'b01, 15'h0005, 8'h00, 0, 1, 1, 8'hA5, 0, 0);
      run_txn(1, 2'b10, 15'h7FFF, 8'h3C, 10, 0, 0, 8'h00, 0, 0);
      run_txn(0, 2'b00, 15'h0100, 8'h00, 0, 0, 0, 8'h00, 0, 0);
      run_txn(1, 2'b01, 15'h2AAA, 8'h81, TO - 1, 0, 0, 8'h00, 0, 0);
      run_txn(1, 2'b01, 15'h5555, 8'h7E, TO, 0, 0, 8'h00, 0, 0);
      run_txn(0, 2'b10, 15'h0F0F, 8'h00, 0, 1, TO - 1, 8'hC3, 0, 0);
      run_txn(0, 2'b10, 15'h0F0F, 8'h00, 0, 1, TO, 8'hC3, 0, 0);
      run_txn(0, 2'b11, 15'h0042, 8'h00, 3, 1, 0, 8'h5A, 0, 0);
      run_txn(1, 2'b11, 15'h1234, 8'h9F, 0, 0, 0, 8'h00, 0, 8);
      run_txn(1, 2'b00, 15'h4321, 8'h66, 0, 0, 0, 8'h00, 0, 0);
      run_txn(1, 2'b10, 15'h0A0A, 8'hF0, 2, 0, 0, 8'h00, 5, 0);
      run_txn(0, 2'b01, 15'h1111, 8'h00, 0, 1, 2, 8'h0F, 0, 0);

      for (int n = 0; n < 40; n++) begin
         wr  = 1'($urandom);
         rsp = ($urandom_range(0, 4) != 0);
         run_txn(wr, SW'($urandom), AW'($urandom), DW'($urandom),
                 $urandom_range(0, 3) == 0 ? $urandom_range(0, TO + 2) : 0,
                 rsp, $urandom_range(0, TO + 1), DW'($urandom),
                 $urandom_range(0, 3) == 0 ? $urandom_range(2, HDR) : 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_bus_master.md
Name: serial_bus_master

Overview:
- Master-side transaction engine for the shared serial bus.
- Accepts one parallel request (slave ID, address, write data, read/write) from the local master module.
- Serialises it onto data_bus_serial with bus_util/rd_wrt framing, honours the slave's wired slave_busy line, and returns read data or a timeout status.
- Sits directly upstream of each slave's serial receiver; it produces exactly the frame that receiver shifts in.

Parameters:
- DATA_WIDTH, 8, width of write/read data word.
- ADDRESS_WIDTH, 15, width of slave-internal address.
- SLAVE_ID_WIDTH, 2, width of slave select field.
- TIMEOUT_CYCLES, 255, maximum cycles waited in WAIT_BUSY or RD_WAIT before abort; minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request strobe from local master.
- req_ready  output  1  engine idle, request accepted when req_valid&&req_ready.
- req_rd_wrt  input  1  1 = write, 0 = read.
- req_slave_id  input  SLAVE_ID_WIDTH  target slave.
- req_addr  input  ADDRESS_WIDTH  target address.
- req_wdata  input  DATA_WIDTH  write data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_WIDTH  read data, valid with resp_valid.
- resp_timeout  output  1  transaction aborted, valid with resp_valid.
- bus_util  output  1  header phase active (start, ID, address).
- rd_wrt  output  1  direction of the current frame.
- data_bus_serial  inout  1  shared serial line; the top level models it as tri1 (pull-up).
- slave_busy  input  1  wired slave busy; Z/X sampled as 0.

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_timeout=0, bus_util=0, rd_wrt=0.
  - Serial driver released (Z); state IDLE.
  - Reset mid-frame aborts immediately and releases the line; no response is issued.
- Request capture: on an accept edge, register all req_* fields. req_ready drops the next cycle and stays low until the cycle after resp_valid.
- All serial fields are sent MSB first, one bit per clock. The driven value changes on the rising edge.
- State machine:
  - IDLE: line released.
  - START (1 cycle): drive 0, bus_util=1, rd_wrt=latched direction.
  - ID (SLAVE_ID_WIDTH cycles): bus_util=1.
  - ADDR (ADDRESS_WIDTH cycles): bus_util=1.
  - WAIT_BUSY: bus_util=0.
    - Write drives the line 1; read releases it.
    - Leave when slave_busy is sampled 0.
    - Write goes to WDATA, read goes to RD_WAIT.
    - Timeout counter runs here.
  - WDATA (DATA_WIDTH cycles): drive data bits, then DONE.
  - RD_WAIT: line released. A sampled 0 is the slave's start bit; go to RDATA. Timeout counter runs here.
  - RDATA (DATA_WIDTH cycles): shift sampled bits into resp_rdata MSB first, then DONE.
  - DONE (1 cycle): line released, resp_valid=1. Back to IDLE next cycle with req_ready=1.
- Timeout:
  - The counter resets on entry to WAIT_BUSY and on entry to RD_WAIT.
  - Abort occurs when the count reaches TIMEOUT_CYCLES without the exit condition. The engine then goes to DONE with resp_timeout=1 and resp_rdata=0.
  - An exit condition in the same cycle as the count limit wins (no timeout).
- rd_wrt holds its value from START until DONE, then returns to 0.
- resp_timeout and resp_rdata hold their values until the next DONE.
- Write latency from the accept edge to resp_valid with slave not busy: 1+SLAVE_ID_WIDTH+ADDRESS_WIDTH+1+DATA_WIDTH+1 = 28 cycles at defaults.
- req_valid while req_ready=0 is ignored; there is no queueing.
- The line is never driven while in IDLE, RD_WAIT, RDATA or DONE.

Test Plan:
- Write, ID 2'b11, addr 15'h1234, wdata 8'h9F (159), slave_busy=0 -> serial line reads 0, 11, 001001000110100, (1 wait), 10011111. bus_util is high for exactly 18 cycles. resp_valid arrives 28 cycles after accept with resp_timeout=0.
- Read, ID 2'b01, addr 15'h0005; the model drives start 0 then 8'hA5 three cycles after ADDR -> resp_rdata=8'hA5, resp_timeout=0. The master never drives the line during the data phase.
- Write with slave_busy held 1 for 10 cycles after ADDR -> line held 1 for those cycles. WDATA starts the cycle after busy is sampled 0; completion is 10 cycles later than the unbusy case.
- Read with no slave response, TIMEOUT_CYCLES=16 -> resp_valid with resp_timeout=1 and resp_rdata=0; req_ready returns 1 the next cycle.
- rst asserted mid-ADDR (cycle 8) -> outputs go to reset values asynchronously and the line goes Z. After rst is released, a new write completes normally.
- req_valid pulsed during an active frame, then back-to-back requests -> mid-frame pulse ignored. The second request is accepted on the first cycle req_ready=1 after DONE.
